spike_gen_l1: RTL and testbench

Layer-1 output stage that turns the weighted trace contributions of a group of synapses into a single output spike event. It sums the `o_cell_out` buses of `p_n_syn` synapse instances into a registered membrane potential and compares it against a loadable threshold. On a crossing it emits a fixed-width event pulse, then holds off through a refractory window. The event pulse is shaped so that it can drive the `i_event` input of a downstream layer's synapse directly.

---
 rtl/spike_gen_l1.sv | 142 ++++++++++++++
 tb/tb_spike_gen_l1.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_gen_l1.sv
// spike_gen_l1: layer-1 output stage. Sums synapse products into a registered
// membrane potential, fires a fixed-width event pulse on a threshold crossing,
// then holds off for a refractory window.
// Optional feature: define SPIKE_THR_ADAPT_EN to raise the threshold by
// i_thr_step (saturating) on every spike.
module spike_gen_l1 #(
    parameter int unsigned p_width        = 9,
    parameter int unsigned p_weight_width = 9,
    parameter int unsigned p_n_syn        = 4,
    parameter int unsigned p_pulse_len    = 4,
    parameter int unsigned p_refractory   = 16,
    parameter int unsigned p_thr_width    = 20,
    parameter int unsigned p_thr_init     = 1000
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic [p_n_syn*(p_width+p_weight_width)-1:0] i_cell_out,
    input  logic                                      i_inhibit,
    input  logic                                      i_thr_load,
    input  logic [p_thr_width-1:0]                    i_thr_value,
    input  logic [7:0]                                i_thr_step,
    output logic                                      o_event,
    output logic [p_thr_width-1:0]                    o_potential,
    output logic [p_thr_width-1:0]                    o_threshold,
    output logic                                      o_busy,
    output logic [7:0]                                o_fire_cnt
);

    localparam int unsigned PROD_W     = p_width + p_weight_width;
    localparam int unsigned CNT_MAX    = (p_pulse_len > p_refractory) ? p_pulse_len : p_refractory;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
    localparam int unsigned PULSE_LOAD = p_pulse_len - 1;
    localparam int unsigned REFR_LOAD  = (p_refractory > 0) ? p_refractory - 1 : 0;
    localparam int unsigned THR_W1     = p_thr_width + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE    = 2'd1,
        REFRACT = 2'd2
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [p_thr_width-1:0] sum_c;
    logic                   fire_c;

    // Unsigned sum of all synapse slices; width is sized so it cannot overflow.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < int'(p_n_syn); i++) begin
            sum_c = sum_c + p_thr_width'(i_cell_out[i*PROD_W +: PROD_W]);
        end
    end

    // Firing decision: only from IDLE, threshold 0 disables, inhibit blocks.
    assign fire_c = (state == IDLE) && (o_potential >= o_threshold) &&
                    (o_threshold != '0) && !i_inhibit;

`ifdef SPIKE_THR_ADAPT_EN
    logic [THR_W1-1:0]      thr_sum_c;
    logic [p_thr_width-1:0] thr_adapt_c;

    // Saturating threshold increment applied on each spike.
    always_comb begin
        thr_sum_c   = {1'b0, o_threshold} + THR_W1'(i_thr_step);
        thr_adapt_c = thr_sum_c[p_thr_width] ? '1 : thr_sum_c[p_thr_width-1:0];
    end
`else
    logic unused_thr_step;
    assign unused_thr_step = ^i_thr_step;
`endif

    // Potential pipeline register and threshold register (explicit load wins).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_potential <= '0;
            o_threshold <= p_thr_width'(p_thr_init);
        end else begin
            o_potential <= sum_c;
            if (i_thr_load) begin
                o_threshold <= i_thr_value;
            end
`ifdef SPIKE_THR_ADAPT_EN
            else if (fire_c) begin
                o_threshold <= thr_adapt_c;
            end
`endif
        end
    end

    // Spike FSM: IDLE -> FIRE (pulse) -> REFRACT (hold-off) -> IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            o_event    <= 1'b0;
            o_busy     <= 1'b0;
            o_fire_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire_c) begin
                        state      <= FIRE;
                        cnt        <= CNT_W'(PULSE_LOAD);
                        o_event    <= 1'b1;
                        o_busy     <= 1'b1;
                        o_fire_cnt <= o_fire_cnt + 8'd1;
                    end
                end
                FIRE: begin
                    if (cnt == '0) begin
                        o_event <= 1'b0;
                        if (p_refractory > 0) begin
                            state <= REFRACT;
                            cnt   <= CNT_W'(REFR_LOAD);
                        end else begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                REFRACT: begin
                    if (cnt == '0) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    o_event <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_gen_l1.sv
// tb_spike_gen_l1: randomized + directed bench for spike_gen_l1 against a
// rise-time based behavioural model. Honors SPIKE_THR_ADAPT_EN like the DUT.
module tb_spike_gen_l1;

    localparam int PL   = 4;
    localparam int RF   = 16;
    localparam int TW   = 20;
    localparam int PW   = 18;
    localparam int NS   = 4;
    localparam int TMAX = (1 << TW) - 1;
`ifdef SPIKE_THR_ADAPT_EN
    localparam bit ADAPT = 1'b1;
`else
    localparam bit ADAPT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [NS*PW-1:0] cell_out;
    logic             inhibit;
    logic             thr_load;
    logic [TW-1:0]    thr_value;
    logic [7:0]       thr_step;
    logic             ev;
    logic [TW-1:0]    potential;
    logic [TW-1:0]    threshold;
    logic             busy;
    logic [7:0]       fire_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spike_gen_l1 dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cell_out  (cell_out),
        .i_inhibit   (inhibit),
        .i_thr_load  (thr_load),
        .i_thr_value (thr_value),
        .i_thr_step  (thr_step),
        .o_event     (ev),
        .o_potential (potential),
        .o_threshold (threshold),
        .o_busy      (busy),
        .o_fire_cnt  (fire_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: outputs derived from the edge index of the last spike.
    int t = 0;
    int last_rise = -1000;
    int m_pot = 0, m_thr = 1000, m_cnt = 0;
    bit model_on = 1'b0;
    bit e_event, e_busy;

    always @(posedge clk) begin
        int  sum;
        bit  idle_before, fire;
        sum = 0;
        for (int i = 0; i < NS; i++) sum += int'(cell_out[i*PW +: PW]);
        if (rst) begin
            m_pot = 0; m_thr = 1000; m_cnt = 0; last_rise = -1000;
            model_on = 1'b1;
        end else begin
            idle_before = (t - 1 - last_rise) >= PL + RF;
            fire = idle_before && (m_pot >= m_thr) && (m_thr != 0) && !inhibit;
            if (fire) begin
                last_rise = t;
                m_cnt = (m_cnt + 1) % 256;
            end
            if (thr_load) m_thr = int'(thr_value);
            else if (fire && ADAPT) m_thr = (m_thr + int'(thr_step) > TMAX) ? TMAX : m_thr + int'(thr_step);
            m_pot = sum;
        end
        e_event = (t - last_rise) < PL;
        e_busy  = (t - last_rise) < PL + RF;
        t++;
    end

    // Every-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        if (model_on) begin
            check("event",     32'(ev),        32'(e_event));
            check("busy",      32'(busy),      32'(e_busy));
            check("potential", 32'(potential), 32'(m_pot));
            check("threshold", 32'(threshold), 32'(m_thr));
            check("fire_cnt",  32'(fire_cnt),  32'(m_cnt));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cells(input int a, input int b, input int c, input int d);
        cell_out = {18'(d), 18'(c), 18'(b), 18'(a)};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic load_thr(input int v);
        thr_value = 20'(v);
        thr_load  = 1'b1;
        tick(1);
        thr_load  = 1'b0;
    endtask

    // Bounded wait for o_event high; cycles = -1 on timeout.
    task automatic wait_rise(input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            tick(1);
            if (ev === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        bit ev_h [0:30];
        bit bz_h [0:30];
        int fc_h [0:30];
        int cyc, cnt;

        rst = 1'b1; cell_out = '0; inhibit = 1'b0; thr_load = 1'b0;
        thr_value = '0; thr_step = 8'd0;
        tick(3);
        check("rst_event", 32'(ev), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_potential", 32'(potential), 0);
        check("rst_threshold", 32'(threshold), 1000);
        check("rst_fire_cnt", 32'(fire_cnt), 0);
        rst = 1'b0;

        // Sub-threshold input.
        set_cells(100, 100, 100, 100);
        tick(1);
        check("pot_400", 32'(potential), 400);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin tick(1); cnt += int'(ev); end
        check("no_spike_400", 32'(cnt), 0);
        check("thr_1000", 32'(threshold), 1000);

        // Crossing, pulse width, busy length and re-fire spacing.
        set_cells(300, 300, 300, 200);
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            ev_h[i] = ev; bz_h[i] = busy; fc_h[i] = int'(fire_cnt);
            if (i == 1) check("pot_1100", 32'(potential), 1100);
        end
        check("ev_k1", 32'(ev_h[1]), 0);
        for (int i = 2; i <= 5; i++) check("ev_pulse", 32'(ev_h[i]), 1);
        check("ev_k6", 32'(ev_h[6]), 0);
        cnt = 0;
        for (int i = 1; i <= 22; i++) cnt += int'(bz_h[i]);
        check("busy_len", 32'(cnt), 20);
        check("fire_cnt_1", 32'(fc_h[5]), 1);
        check("ev_k22", 32'(ev_h[22]), 0);
        check("ev_k23", 32'(ev_h[23]), 1);
        check("fire_cnt_2", 32'(fc_h[23]), 2);
        set_cells(0, 0, 0, 0);
        tick(30);

        // Inhibit blocks firing; raised mid-pulse it does not truncate.
        do_reset();
        inhibit = 1'b1;
        set_cells(300, 300, 300, 200);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin tick(1); cnt += int'(ev); end
        check("inhibit_block", 32'(cnt), 0);
        inhibit = 1'b0;
        wait_rise(4, cyc);
        check("inhibit_release_rise", 32'(cyc >= 1 && cyc <= 2), 1);
        inhibit = 1'b1;
        cnt = 1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (ev !== 1'b1) break;
            cnt++;
        end
        check("inhibit_pulse_width", 32'(cnt), 4);
        inhibit = 1'b0;
        set_cells(0, 0, 0, 0);
        tick(25);

        // Threshold 0 disables; threshold equal to the sum fires.
        load_thr(0);
        check("thr_0", 32'(threshold), 0);
        set_cells(1250, 1250, 1250, 1250);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin tick(1); cnt += int'(ev); end
        check("thr0_no_fire", 32'(cnt), 0);
        load_thr(5000);
        check("thr_5000", 32'(threshold), 5000);
        wait_rise(5, cyc);
        check("fire_at_equal", 32'(cyc != -1), 1);
        set_cells(0, 0, 0, 0);
        tick(30);

        // Held supra-threshold input: adaptation limits the number of spikes.
        do_reset();
        thr_step = 8'd50;
        set_cells(300, 300, 300, 300);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (ev === 1'b1 && (i == 0 || ev_h[0] == 1'b0)) cnt++;
            ev_h[0] = ev;
        end
        check("spike_count_held", 32'(cnt), ADAPT ? 5 : 10);
        check("thr_after_held", 32'(threshold), ADAPT ? 1250 : 1000);
        thr_step = 8'd0;

        // Reset during the second pulse cycle truncates the pulse.
        do_reset();
        set_cells(300, 300, 300, 200);
        wait_rise(5, cyc);
        check("pre_rst_rise", 32'(cyc != -1), 1);
        tick(1);
        check("pre_rst_ev2", 32'(ev), 1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_event", 32'(ev), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_thr", 32'(threshold), 1000);
        check("mid_rst_cnt", 32'(fire_cnt), 0);
        rst = 1'b0;

        // Long run to wrap the spike counter.
        tick(256 * (PL + RF + 1) + 10);

        // Randomized stimulus.
        for (int i = 0; i < 3000; i++) begin
            set_cells($urandom_range(0, 600), $urandom_range(0, 600),
                      $urandom_range(0, 600), $urandom_range(0, 600));
            inhibit   = ($urandom % 8) == 0;
            thr_load  = ($urandom % 25) == 0;
            thr_value = ($urandom % 5 == 0) ? 20'd0 : 20'($urandom_range(200, 2400));
            thr_step  = 8'($urandom);
            rst       = ($urandom % 300) == 0;
            tick(1);
        end
        rst = 1'b0; thr_load = 1'b0; inhibit = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
